// File: rtl/selector_pkg.sv
// Shared definitions for the 1-to-4 distributor and the 4-to-1 selector:
// port codes, default data width and a port-code decoder.
package selector_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] PORT0 = 2'b00;
    localparam logic [1:0] PORT1 = 2'b01;
    localparam logic [1:0] PORT2 = 2'b10;
    localparam logic [1:0] PORT3 = 2'b11;

    // One-hot port select from a 2-bit port code.
    function automatic logic [3:0] port_onehot(input logic [1:0] op);
        logic [3:0] sel;
        sel = 4'b0000;
        case (op)
            PORT0:   sel = 4'b0001;
            PORT1:   sel = 4'b0010;
            PORT2:   sel = 4'b0100;
            PORT3:   sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/distributor_1to4_slot.sv
// One-entry output slot: holds a single word for one consumer port.
// A load and a drain in the same cycle replace the word with no bubble.
module distributor_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             free
);

    // Slot can take a new word when empty or being emptied this cycle.
    assign free = !valid || drain;

    // Data register only changes on a load; it keeps its value after delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    // Valid flag: set by a load, cleared by a drain without a concurrent load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/distributor_1to4.sv
// 1-to-4 distributor: routes each accepted word to the one-entry slot
// selected by in_op. Ports never block each other; in_ready only looks
// at the addressed slot.
module distributor_1to4
    import selector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       acc_cnt
);

    logic [3:0]       slot_free;
    logic [3:0]       slot_load;
    logic [WIDTH-1:0] slot_data [4];
    logic             accept;

    assign in_ready  = slot_free[in_op];
    assign accept    = in_valid && in_ready;
    assign slot_load = {4{accept}} & port_onehot(in_op);

    for (genvar g = 0; g < 4; g++) begin : g_slot
        distributor_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (slot_load[g]),
            .load_data (in_data),
            .drain     (out_ready[g]),
            .data      (slot_data[g]),
            .valid     (out_valid[g]),
            .free      (slot_free[g])
        );
    end

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];

    // Accepted-word counter, wraps modulo 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= 8'd0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_distributor_1to4.sv
// Self-checking bench for distributor_1to4: directed vector table, then
// scoreboard-checked sequences (round-robin wrap, mid-run reset, random).
module tb_distributor_1to4;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [1:0]  in_op;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  acc_cnt;

    int n_total;
    int n_pass;

    logic [31:0] q [4][$];
    logic [7:0]  exp_acc;
    int          deliv_cnt [4];

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [31:0] d;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_ov;
        logic [7:0]  e_acc;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [12];

    distributor_1to4 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_cnt   (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_data(input int n);
        case (n)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic sb_clear();
        for (int n = 0; n < 4; n++) begin
            q[n].delete();
            deliv_cnt[n] = 0;
        end
        exp_acc = 8'd0;
    endtask

    // Apply a reset away from the clock edge; release 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = 2'd0; in_data = '0; out_ready = 4'b0000;
        #1;
        check("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check("rst_acc_cnt", {24'd0, acc_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_clear();
    endtask

    // One cycle against the scoreboard: accepted words queue per port,
    // every delivery must match the oldest queued word for that port.
    task automatic drive_cycle(input logic v, input logic [1:0] op,
                               input logic [31:0] d, input logic [3:0] ordy);
        logic        exp_rdy;
        logic        acc;
        logic [3:0]  stall;
        logic [31:0] snap [4];
        in_valid = v; in_op = op; in_data = d; out_ready = ordy;
        #1;
        exp_rdy = (q[op].size() == 0) || ordy[op];
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        for (int n = 0; n < 4; n++) begin
            snap[n]  = get_data(n);
            stall[n] = (q[n].size() != 0) && !ordy[n];
            if (q[n].size() != 0 && ordy[n]) begin
                check($sformatf("deliver_p%0d", n), get_data(n), q[n][0]);
                void'(q[n].pop_front());
                deliv_cnt[n]++;
            end
        end
        if (acc) begin
            q[op].push_back(d);
            exp_acc = exp_acc + 8'd1;
        end
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) begin
            check($sformatf("out_valid_p%0d", n), {31'd0, out_valid[n]},
                  {31'd0, (q[n].size() != 0)});
            if (stall[n]) check($sformatf("stable_p%0d", n), get_data(n), snap[n]);
        end
        check("acc_cnt", {24'd0, acc_cnt}, {24'd0, exp_acc});
        if (acc) check("loaded_data", get_data(int'(op)), d);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        sb_clear();

        tbl[0]  = '{1'b1, 2'd2, 32'h0000_0002, 4'b0000, 1'b1, 4'b0100, 8'd1, 32'h0000_0002};
        tbl[1]  = '{1'b1, 2'd1, 32'h0000_0011, 4'b0000, 1'b1, 4'b0110, 8'd2, 32'h0000_0011};
        tbl[2]  = '{1'b1, 2'd1, 32'h0000_0022, 4'b0000, 1'b0, 4'b0110, 8'd2, 32'h0000_0011};
        tbl[3]  = '{1'b1, 2'd3, 32'h0000_0033, 4'b0000, 1'b1, 4'b1110, 8'd3, 32'h0000_0033};
        tbl[4]  = '{1'b1, 2'd0, 32'h0000_000A, 4'b0000, 1'b1, 4'b1111, 8'd4, 32'h0000_000A};
        tbl[5]  = '{1'b1, 2'd0, 32'h0000_000B, 4'b0001, 1'b1, 4'b1111, 8'd5, 32'h0000_000B};
        tbl[6]  = '{1'b0, 2'd1, 32'h0000_0099, 4'b0000, 1'b0, 4'b1111, 8'd5, 32'h0000_0011};
        tbl[7]  = '{1'b0, 2'd2, 32'h0000_0099, 4'b0100, 1'b1, 4'b1011, 8'd5, 32'h0000_0002};
        tbl[8]  = '{1'b1, 2'd2, 32'h0000_0044, 4'b1000, 1'b1, 4'b0111, 8'd6, 32'h0000_0044};
        tbl[9]  = '{1'b1, 2'd3, 32'h0000_0055, 4'b0000, 1'b1, 4'b1111, 8'd7, 32'h0000_0055};
        tbl[10] = '{1'b0, 2'd0, 32'h0000_0000, 4'b1111, 1'b1, 4'b0000, 8'd7, 32'h0000_000B};
        tbl[11] = '{1'b1, 2'd1, 32'h0000_0066, 4'b0000, 1'b1, 4'b0010, 8'd8, 32'h0000_0066};

        do_reset();
        for (int op = 0; op < 4; op++) begin
            in_op = 2'(op);
            #1;
            check($sformatf("post_rst_ready_op%0d", op), {31'd0, in_ready}, 32'd1);
        end

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            in_valid = tbl[i].v; in_op = tbl[i].op; in_data = tbl[i].d; out_ready = tbl[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
            @(posedge clk); #1;
            check($sformatf("vec%0d_out_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].e_ov});
            check($sformatf("vec%0d_acc_cnt", i), {24'd0, acc_cnt}, {24'd0, tbl[i].e_acc});
            check($sformatf("vec%0d_data", i), get_data(int'(tbl[i].op)), tbl[i].e_data);
        end

        // 256 round-robin accepts with all consumers ready: counter wraps,
        // each port sees 64 words in order.
        do_reset();
        for (int i = 0; i < 256; i++)
            drive_cycle(1'b1, 2'(i % 4), $urandom, 4'b1111);
        check("wrap_acc_cnt", {24'd0, acc_cnt}, 32'd0);
        drive_cycle(1'b0, 2'd0, 32'd0, 4'b1111);
        for (int n = 0; n < 4; n++)
            check($sformatf("rr_deliv_cnt_p%0d", n), deliv_cnt[n], 64);

        // Fill every slot, then reset asynchronously between edges.
        do_reset();
        for (int n = 0; n < 4; n++)
            drive_cycle(1'b1, 2'(n), 32'hC0DE_0000 + n, 4'b0000);
        check("full_out_valid", {28'd0, out_valid}, 32'h0000_000F);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {28'd0, out_valid}, 32'd0);
        check("async_rst_acc_cnt", {24'd0, acc_cnt}, 32'd0);
        for (int n = 0; n < 4; n++)
            check($sformatf("async_rst_data_p%0d", n), get_data(n), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_clear();
        for (int op = 0; op < 4; op++) begin
            in_op = 2'(op);
            #1;
            check($sformatf("release_ready_op%0d", op), {31'd0, in_ready}, 32'd1);
        end
        drive_cycle(1'b1, 2'd3, 32'h1234_5678, 4'b0000);

        // Random traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 10000; i++)
            drive_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        $urandom, 4'($urandom_range(0, 15)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
